// File: rtl/counter_mon_pkg.sv
// Shared types for the counter step checker: event codes, event record and arming FSM states.
package counter_mon_pkg;

  localparam int REC_VAL_W = 4;

  typedef enum logic [1:0] {
    EVT_NONE      = 2'd0,
    EVT_UP_WRAP   = 2'd1,
    EVT_DOWN_WRAP = 2'd2,
    EVT_MISMATCH  = 2'd3
  } evt_type_e;

  typedef struct packed {
    evt_type_e              typ;
    logic [REC_VAL_W-1:0]   exp;
    logic [REC_VAL_W-1:0]   act;
  } evt_rec_t;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } state_e;

endpackage

// File: rtl/counter_step_checker_if.sv
// Event-record stream from the checker: valid/ready handshake plus the head record fields.
interface counter_step_checker_if #(parameter int WIDTH = 4);
  import counter_mon_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  evt_type_e        evt_type;
  logic [WIDTH-1:0] evt_exp;
  logic [WIDTH-1:0] evt_act;

  modport master (output evt_valid, output evt_type, output evt_exp, output evt_act,
                  input  evt_ready);
  modport slave  (input  evt_valid, input  evt_type, input  evt_exp, input  evt_act,
                  output evt_ready);
endinterface

// File: rtl/counter_evt_fifo.sv
// Event queue: pointers carry a wrap bit, push/pop may coincide at any fill, head is registered.
module counter_evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_head,
  output logic         o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_head, w_head_nxt;
  logic         w_full, w_pop, w_wr_en;

  assign o_valid = (r_wr != r_rd);
  assign o_head  = r_head;

  always_comb begin
    w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_pop    = o_valid && i_ready;
    w_wr_en  = i_push && (!w_full || w_pop);
    o_drop   = i_push && w_full && !w_pop;
    w_rd_nxt = r_rd + (AW+1)'(w_pop);
    w_wr_nxt = r_wr + (AW+1)'(w_wr_en);
    // A record written into an otherwise empty queue bypasses storage straight to the head
    if (w_wr_nxt == w_rd_nxt)
      w_head_nxt = '0;
    else if (w_wr_en && (r_wr == w_rd_nxt))
      w_head_nxt = i_din;
    else
      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_rd   <= w_rd_nxt;
      r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/counter_step_checker.sv
// Monitors an up/down counter: predicts each step, reports wraps/mismatches, keeps saturating stats.
module counter_step_checker
  import counter_mon_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_rst,
  input  logic                   cnt_mode_sel,
  input  logic [WIDTH-1:0]       cnt_dout,
  input  logic                   clr,
  counter_step_checker_if.master evt,
  output logic [CNT_W-1:0]       up_wraps,
  output logic [CNT_W-1:0]       down_wraps,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   armed,
  output logic                   ovf
);
  localparam int REC_W = 2 + 2*WIDTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  logic [WIDTH-1:0] r_dout_p0;
  logic             r_mode_p0, r_rst_p0;
  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] w_exp;
  evt_type_e        w_type;
  logic             w_chk, w_push, w_drop, w_valid;
  logic [REC_W-1:0] w_head;
  logic [CNT_W-1:0] r_up_wraps, r_down_wraps, r_err_cnt;
  logic             r_ovf;

  // Stage p0: previous counter sample and the controls that produced the next value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_p0 <= '0;
      r_mode_p0 <= 1'b0;
      r_rst_p0  <= 1'b0;
    end else begin
      r_dout_p0 <= cnt_dout;
      r_mode_p0 <= cnt_mode_sel;
      r_rst_p0  <= cnt_rst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UNARMED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == UNARMED && r_rst_p0) w_state_nxt = ARMED;
  end

  always_comb begin
    armed = (r_state == ARMED);
  end

  // The arming edge itself is checked against zero, so checking is on whenever p0 reset is seen
  always_comb begin
    w_exp  = r_rst_p0 ? '0 : (r_mode_p0 ? r_dout_p0 + WIDTH'(1) : r_dout_p0 - WIDTH'(1));
    w_chk  = (r_state == ARMED) || r_rst_p0;
    w_type = EVT_NONE;
    if (cnt_dout != w_exp)
      w_type = EVT_MISMATCH;
    else if (!r_rst_p0 && r_mode_p0 && (r_dout_p0 == '1))
      w_type = EVT_UP_WRAP;
    else if (!r_rst_p0 && !r_mode_p0 && (r_dout_p0 == '0))
      w_type = EVT_DOWN_WRAP;
    w_push = w_chk && (w_type != EVT_NONE);
  end

  counter_evt_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({w_type, w_exp, cnt_dout}),
    .i_ready (evt.evt_ready),
    .o_valid (w_valid),
    .o_head  (w_head),
    .o_drop  (w_drop)
  );

  assign evt.evt_valid = w_valid;
  assign evt.evt_type  = evt_type_e'(w_head[REC_W-1 -: 2]);
  assign evt.evt_exp   = w_head[2*WIDTH-1 -: WIDTH];
  assign evt.evt_act   = w_head[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_wraps   <= '0;
      r_down_wraps <= '0;
      r_err_cnt    <= '0;
      r_ovf        <= 1'b0;
    end else if (clr) begin
      r_up_wraps   <= '0;
      r_down_wraps <= '0;
      r_err_cnt    <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_up_wraps   <= sat_inc(r_up_wraps,   w_push && (w_type == EVT_UP_WRAP));
      r_down_wraps <= sat_inc(r_down_wraps, w_push && (w_type == EVT_DOWN_WRAP));
      r_err_cnt    <= sat_inc(r_err_cnt,    w_push && (w_type == EVT_MISMATCH));
      r_ovf        <= r_ovf | w_drop;
    end
  end

  assign up_wraps   = r_up_wraps;
  assign down_wraps = r_down_wraps;
  assign err_cnt    = r_err_cnt;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_counter_step_checker.sv
// Directed bench for counter_step_checker: drives a modelled counter and scoreboards event records.
module tb_counter_step_checker;
  import counter_mon_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cnt_rst = 1'b0;
  logic             cnt_mode_sel = 1'b1;
  logic [WIDTH-1:0] cnt_dout = 4'd9;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] up_wraps, down_wraps, err_cnt;
  logic             armed, ovf;

  always #5 clk = ~clk;

  counter_step_checker_if #(.WIDTH(WIDTH)) evt_if ();

  counter_step_checker #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_rst      (cnt_rst),
    .cnt_mode_sel (cnt_mode_sel),
    .cnt_dout     (cnt_dout),
    .clr          (clr),
    .evt          (evt_if.master),
    .up_wraps     (up_wraps),
    .down_wraps   (down_wraps),
    .err_cnt      (err_cnt),
    .armed        (armed),
    .ovf          (ovf)
  );

  typedef struct {
    logic [1:0] t;
    logic [3:0] e;
    logic [3:0] a;
  } rec_t;

  rec_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_pd;
  logic       m_pm, m_pr, m_armed, m_ovf;
  int         m_up, m_down, m_err, up_total;
  logic [3:0] qe [7];
  logic [3:0] qa [7];
  int         order [4] = '{1, 2, 3, 6};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] capped(input int v);
    return (v > 255) ? 32'd255 : 32'(v);
  endfunction

  task automatic model_reset();
    sb.delete();
    m_pd = '0; m_pm = 1'b0; m_pr = 1'b0; m_armed = 1'b0; m_ovf = 1'b0;
    m_up = 0; m_down = 0; m_err = 0;
  endtask

  task automatic head_is(input string tag, input logic [1:0] t, input logic [3:0] e, input logic [3:0] a);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
    check({tag, "_type"},  32'(evt_if.evt_type),  32'(t));
    check({tag, "_exp"},   32'(evt_if.evt_exp),   32'(e));
    check({tag, "_act"},   32'(evt_if.evt_act),   32'(a));
  endtask

  // One clock: compare outputs to the scoreboard, predict this edge, then advance the counter
  task automatic tick();
    logic [3:0] e;
    logic [1:0] t;
    logic       chk, drop;
    @(negedge clk);
    check("evt_valid", 32'(evt_if.evt_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      check("head_type", 32'(evt_if.evt_type), 32'(sb[0].t));
      check("head_exp",  32'(evt_if.evt_exp),  32'(sb[0].e));
      check("head_act",  32'(evt_if.evt_act),  32'(sb[0].a));
    end
    check("armed",      32'(armed),      32'(m_armed));
    check("up_wraps",   32'(up_wraps),   capped(m_up));
    check("down_wraps", 32'(down_wraps), capped(m_down));
    check("err_cnt",    32'(err_cnt),    capped(m_err));
    check("ovf",        32'(ovf),        32'(m_ovf));
    if (evt_if.evt_ready && sb.size() > 0) sb.delete(0);
    chk  = m_armed || m_pr;
    e    = m_pr ? 4'd0 : (m_pm ? m_pd + 4'd1 : m_pd - 4'd1);
    t    = 2'd0;
    drop = 1'b0;
    if (chk) begin
      if (cnt_dout != e)                  t = 2'd3;
      else if (!m_pr && m_pm && m_pd == 15) t = 2'd1;
      else if (!m_pr && !m_pm && m_pd == 0) t = 2'd2;
    end
    if (t != 2'd0) begin
      if (sb.size() < DEPTH) sb.push_back('{t, e, cnt_dout});
      else drop = 1'b1;
    end
    if (t == 2'd1) up_total++;
    if (clr) begin
      m_up = 0; m_down = 0; m_err = 0; m_ovf = 1'b0;
    end else begin
      if (t == 2'd1) m_up++;
      if (t == 2'd2) m_down++;
      if (t == 2'd3) m_err++;
      if (drop) m_ovf = 1'b1;
    end
    if (m_pr) m_armed = 1'b1;
    m_pd = cnt_dout; m_pm = cnt_mode_sel; m_pr = cnt_rst;
    @(posedge clk);
    #1;
    cnt_dout = cnt_rst ? 4'd0 : (cnt_mode_sel ? cnt_dout + 4'd1 : cnt_dout - 4'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_armed", 32'(armed), 32'd0);
    check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_type",  32'(evt_if.evt_type), 32'd0);
    check("rst_err",   32'(err_cnt), 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);

    repeat (10) tick();
    check("unarmed_valid", 32'(evt_if.evt_valid), 32'd0);
    check("unarmed_armed", 32'(armed), 32'd0);

    // Arm, then count up through one wrap
    evt_if.evt_ready = 1'b0;
    cnt_rst = 1'b1;
    tick();
    cnt_rst = 1'b0;
    repeat (20) tick();
    check("arm_armed", 32'(armed), 32'd1);
    check("arm_up_wraps", 32'(up_wraps), 32'd1);
    check("arm_err", 32'(err_cnt), 32'd0);
    head_is("up_wrap", 2'd1, 4'd0, 4'd0);

    // Down through zero
    cnt_mode_sel = 1'b0;
    repeat (12) tick();
    check("down_wraps", 32'(down_wraps), 32'd1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    head_is("down_wrap", 2'd2, 4'd15, 4'd15);
    evt_if.evt_ready = 1'b1;
    tick();

    // Glitch to 7 where 5 is due, then count on from 7
    cnt_mode_sel = 1'b1;
    for (int i = 0; i < 40 && cnt_dout != 4'd4; i++) tick();
    check("reach_4", 32'(cnt_dout), 32'd4);
    tick();
    cnt_dout = 4'd7;
    evt_if.evt_ready = 1'b0;
    tick();
    repeat (5) tick();
    check("mm_err", 32'(err_cnt), 32'd1);
    head_is("mismatch", 2'd3, 4'd5, 4'd7);
    evt_if.evt_ready = 1'b1;
    tick();
    check("mm_single", 32'(evt_if.evt_valid), 32'd0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_err", 32'(err_cnt), 32'd0);
    check("clr_up", 32'(up_wraps), 32'd0);

    // Six mismatches into a stalled queue of four
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      qe[i] = cnt_dout;
      cnt_dout = cnt_dout + 4'd4;
      qa[i] = cnt_dout;
      tick();
    end
    check("full_ovf", 32'(ovf), 32'd1);
    check("full_err", 32'(err_cnt), 32'd6);
    head_is("full_head0", 2'd3, qe[0], qa[0]);
    evt_if.evt_ready = 1'b1;
    qe[6] = cnt_dout;
    cnt_dout = cnt_dout + 4'd4;
    qa[6] = cnt_dout;
    tick();
    check("pushpop_err", 32'(err_cnt), 32'd7);
    for (int k = 0; k < 4; k++) begin
      head_is("drain", 2'd3, qe[order[k]], qa[order[k]]);
      tick();
    end

    // Saturation of the up-wrap statistic
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up_total = 0;
    for (int i = 0; i < 6000 && up_total < 300; i++) tick();
    check("sat_total", 32'(up_total), 32'd300);
    check("sat_up", 32'(up_wraps), 32'd255);

    // clr on the same edge as a wrap
    for (int i = 0; i < 20 && cnt_dout != 4'd0; i++) tick();
    evt_if.evt_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clrwrap_up", 32'(up_wraps), 32'd0);
    check("clrwrap_armed", 32'(armed), 32'd1);
    head_is("clrwrap", 2'd1, 4'd0, 4'd0);

    // Asynchronous reset with a non-empty queue
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_armed", 32'(armed), 32'd0);
    check("arst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("arst_type", 32'(evt_if.evt_type), 32'd0);
    check("arst_exp", 32'(evt_if.evt_exp), 32'd0);
    check("arst_act", 32'(evt_if.evt_act), 32'd0);
    check("arst_up", 32'(up_wraps), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    repeat (10) tick();
    check("post_valid", 32'(evt_if.evt_valid), 32'd0);
    check("post_armed", 32'(armed), 32'd0);
    check("post_err", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_step_checker.md
# counter_step_checker

Downstream monitor for the 4-bit up/down counter. It samples the counter's `dout` together with the `mode_sel` and `rst` that drive the counter, and predicts each next value. It reports wrap-arounds and step mismatches as event records through a valid/ready queue, and keeps saturating statistics. It is synthesizable and sits beside the counter in the design, or in the bench, as a hardware checker.

## Interface
- `WIDTH`, 4: counter width; must match the counter.
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥2.
- `CNT_W`, 8: width of the statistics counters.

- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cnt_rst` input 1: the counter's synchronous reset, as driven to the counter.
- `cnt_mode_sel` input 1: the counter's mode; 1 = up, 0 = down.
- `cnt_dout` input WIDTH: the counter's output.
- `clr` input 1: synchronous clear of `up_wraps`, `down_wraps`, `err_cnt` and `ovf`.
- `evt_valid` output 1: the queue head is valid.
- `evt_ready` input 1: the consumer accepts the head.
- `evt_type` output 2: head event type.
- `evt_exp` output WIDTH: head event's expected value.
- `evt_act` output WIDTH: head event's actual value.
- `up_wraps` output CNT_W: saturating count of UP_WRAP events.
- `down_wraps` output CNT_W: saturating count of DOWN_WRAP events.
- `err_cnt` output CNT_W: saturating count of MISMATCH events.
- `armed` output 1: checking is active.
- `ovf` output 1: sticky flag; an event was dropped because the queue was full.

## Operation
- Every posedge, register `p_dout`, `p_mode` and `p_rst` from the inputs.
- **Prediction (mod 2^WIDTH):**
  - `exp = p_rst ? 0 : (p_mode ? p_dout+1 : p_dout-1)`.
  - Use WIDTH-bit wrap arithmetic; carry and borrow are discarded.
- **FSM `UNARMED` → `ARMED`:**
  - Reset enters `UNARMED`. The counter's value is unknown until it has been reset.
  - `UNARMED` → `ARMED` at the posedge where `p_rst`=1. This is the first edge after `cnt_rst` was sampled high.
  - No `UNARMED` → `ARMED` path is exempt from checking: the edge where `p_rst` is sampled high also checks `cnt_dout` against 0.
  - `ARMED` has no exit other than `rst_n`. `armed` = (state == `ARMED`).
- **Classification**, applied when `ARMED` at edge k, using the sampled `cnt_dout`. Exactly one of:
  - **MISMATCH:** `cnt_dout != exp`.
  - **UP_WRAP:** match with `!p_rst`, `p_mode`=1 and `p_dout` = all-ones.
  - **DOWN_WRAP:** match with `!p_rst`, `p_mode`=0 and `p_dout` = 0.
  - **None:** any other match.
  - MISMATCH has priority, so a wrong value at a wrap point is a MISMATCH only.
- **Resync:** the next prediction always starts from the actual sampled value. One glitch yields exactly one MISMATCH.
- **Event record:** {`evt_type`, `evt_exp`, `evt_act`=`cnt_dout`}, pushed into the queue.
  - If the queue is full and not popping this edge, the record is dropped and `ovf` is set.
  - Statistics still count dropped events.
- **Queue handshake:**
  - A pop occurs on `evt_valid && evt_ready`.
  - Push and pop on the same edge are legal at any fill level, including full.
  - Order is FIFO.
  - `evt_type`/`evt_exp`/`evt_act` stay stable while `evt_valid` && !`evt_ready`.
- **Statistics:** saturate at 2^CNT_W−1 and never wrap.
  - `clr` has priority over a same-edge increment: the result is 0.
  - `clr` does not touch the queue or the FSM.

## Timing
- Values sampled at edge k produce their event at edge k. `evt_valid` rises after edge k when the queue was empty, i.e. one-cycle latency.
- Statistics update at the same edge.
- `armed` is high after the edge where `p_rst`=1, which is two edges after `cnt_rst` is driven high before edge k−1.
- `rst_n` asserted, at any time including mid-operation, forces the following state immediately (async):
  - state `UNARMED`;
  - queue empty, `evt_valid`=0;
  - `evt_type`/`evt_exp`/`evt_act`=0;
  - all statistics 0, `ovf`=0;
  - `p_*`=0.
- On release of `rst_n`, nothing is checked until re-armed.

## Structure
- Package `counter_mon_pkg`:
  - `evt_type_e` (2 bits): `EVT_NONE`=0, `EVT_UP_WRAP`=1, `EVT_DOWN_WRAP`=2, `EVT_MISMATCH`=3;
  - packed `evt_rec_t` {type, exp, act};
  - `state_e` {`UNARMED`, `ARMED`}.
- Sub-module `counter_evt_fifo`:
  - parameterised on width and depth;
  - pointers with an extra wrap bit;
  - simultaneous push/pop; registered head outputs.
- The top level holds the prediction, classification, FSM and saturating counters.

## Test plan
- **Reset:** `rst_n`=0 mid-stream with a non-empty queue → after reset all outputs 0, `armed`=0, `evt_valid`=0; 10 correct counts without `cnt_rst` → no events.
- **Arm and up wrap:** `cnt_rst`=1 for one cycle, then 20 correct up counts → `armed`=1; one UP_WRAP with exp=act=0; `up_wraps`=1; `err_cnt`=0.
- **Down wrap:** `mode_sel`=0 from 0 → DOWN_WRAP with exp=act=15; `down_wraps`=1.
- **Injected mismatch:** force `cnt_dout`=7 where 5 is expected, then correct counting from 7 → single MISMATCH exp=5 act=7; `err_cnt`=1; no further events.
- **Queue full:** `evt_ready`=0 and 6 mismatches → 4 queued, `ovf`=1, `err_cnt`=6; drain → the first 4 records are returned in order; push+pop while full is accepted.
- **Saturation/clr:** 300 up wraps → `up_wraps`=255; `clr` coincident with a wrap → `up_wraps`=0 on the next cycle, queue unaffected.
